// File: rtl/mdu_pkg.sv
// Shared encodings and op-class helpers for the sequential multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OpNop   = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8,
        OpMsub  = 4'd9,
        OpMsubu = 4'd10
    } op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic op_is_mac(input logic [3:0] op);
        return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
    endfunction

    function automatic logic op_is_sub(input logic [3:0] op);
        return (op == OpMsub) || (op == OpMsubu);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, emit quotient bit.
module mdu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qbit;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        qbit    = ~diff[WIDTH];  // no borrow: divisor fits
        rem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/seq_mdu.sv
// Sequential multiply/divide unit with HI/LO; one bit per cycle, WIDTH-cycle latency.
// Define SEQ_MDU_ACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module seq_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    // Asynchronous assert, synchronous release.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [W2-1:0]    work_q;
    logic             neg_q, rem_neg_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             in_signed, in_div, in_iter, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        in_signed = op_is_signed(op);
        in_div    = op_is_div(op);
        in_iter   = op_is_mul(op) | in_div;
`ifdef SEQ_MDU_ACC_EN
        in_iter   = in_iter | op_is_mac(op);
`endif
        a_neg     = in_signed & src_a[WIDTH-1];
        b_neg     = in_signed & src_b[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
    end

    logic [WIDTH-1:0] div_rem, div_quo, quo_res, rem_res, commit_hi, commit_lo;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next, step_next, prod_res;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (work_q[W2-1:WIDTH]),
        .quo_in  (work_q[WIDTH-1:0]),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    always_comb begin
        mul_sum   = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        step_next = op_is_div(op_q) ? {div_rem, div_quo} : mul_next;
        prod_res  = neg_q ? -mul_next : mul_next;
        quo_res   = neg_q ? -div_quo : div_quo;
        rem_res   = rem_neg_q ? -div_rem : div_rem;
        if (op_is_div(op_q)) begin
            {commit_hi, commit_lo} = {rem_res, quo_res};
`ifdef SEQ_MDU_ACC_EN
        end else if (op_is_mac(op_q)) begin
            if (op_is_sub(op_q)) {commit_hi, commit_lo} = {hi_q, lo_q} - prod_res;
            else                 {commit_hi, commit_lo} = {hi_q, lo_q} + prod_res;
`endif
        end else begin
            {commit_hi, commit_lo} = prod_res;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !cancel) begin
                        if (in_iter) begin
                            state_q   <= StRun;
                            count_q   <= '0;
                            op_q      <= op;
                            opnd_q    <= in_div ? b_mag : a_mag;
                            work_q    <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                            // Divide by zero keeps an all-ones quotient regardless of sign.
                            neg_q     <= (a_neg ^ b_neg) & (!in_div || (src_b != '0));
                            rem_neg_q <= a_neg & in_div;
                        end else if (op == OpMthi) begin
                            hi_q <= src_a;
                        end else if (op == OpMtlo) begin
                            lo_q <= src_a;
                        end
                    end
                end
                StRun: begin
                    if (cancel) begin
                        state_q <= StIdle;
                    end else begin
                        work_q  <= step_next;
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_q <= StIdle;
                            hi_q    <= commit_hi;
                            lo_q    <= commit_lo;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mdu.sv
// Directed, table-driven bench for seq_mdu plus hand-written cancel/reset/busy sequences.
module tb_seq_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    seq_mdu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue an iterative op, scramble inputs after acceptance, then check latency, done, HI/LO.
    task automatic run_iter(input string name, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] ehi,
                            input logic [W-1:0] elo);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); src_a = $urandom; src_b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, 64'(n), 64'(W));
        chk({name, " done_pulse"}, 64'(done), 64'd1);
        chk({name, " hi"}, 64'(hi), 64'(ehi));
        chk({name, " lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({name, " done_drop"}, 64'(done), 64'd0);
    endtask

    task automatic mt(input logic [3:0] o, input logic [W-1:0] data);
        @(negedge clk);
        start = 1'b1; op = o; src_a = data;
        @(negedge clk);
        start = 1'b0;
        chk("mt busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        int done_seen;

        vecs[0]  = '{"mult_m3x7",     OpMult,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{"multu_max",     OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"mult_minxmin",  OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"mult_maxx2",    OpMult,  32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE};
        vecs[4]  = '{"multu_6x7",     OpMultu, 32'd6,        32'd7,        32'h00000000, 32'd42};
        vecs[5]  = '{"div_m7d2",      OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{"div_7dm2",      OpDiv,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"divu_7d0",      OpDivu,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[8]  = '{"div_m7d0",      OpDiv,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9]  = '{"div_mindm1",    OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{"divu_100d7",    OpDivu,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[11] = '{"divu_maxd1",    OpDivu,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);

        foreach (vecs[i]) run_iter(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                                   vecs[i].hi, vecs[i].lo);

        mt(OpMtlo, 32'd0);
        mt(OpMthi, 32'h1234);
        chk("mthi hi", 64'(hi), 64'h1234);
        chk("mtlo lo", 64'(lo), 64'd0);
        chk("mt done", 64'(done), 64'd0);
`ifdef SEQ_MDU_ACC_EN
        run_iter("madd_2x3", OpMadd, 32'd2, 32'd3, 32'h1234, 32'd6);
        run_iter("msub_2x3", OpMsub, 32'd2, 32'd3, 32'h1234, 32'd0);
        run_iter("msubu_1x1", OpMsubu, 32'd1, 32'd1, 32'h1233, 32'hFFFFFFFF);
`else
        @(negedge clk);
        start = 1'b1; op = OpMadd; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("madd_nop busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("madd_nop done", 64'(done), 64'd0);
        chk("madd_nop hi", 64'(hi), 64'h1234);
        chk("madd_nop lo", 64'(lo), 64'd0);
`endif

        // Cancel an in-flight divide.
        mt(OpMthi, 32'hAAAA);
        mt(OpMtlo, 32'h5555);
        @(negedge clk);
        start = 1'b1; op = OpDivu; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("cancel busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel hi", 64'(hi), 64'hAAAA);
        chk("cancel lo", 64'(lo), 64'h5555);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        chk("cancel no_done", 64'(done_seen), 64'd0);
        run_iter("post_cancel_multu", OpMultu, 32'd6, 32'd7, 32'd0, 32'd42);

        // MTLO while busy is ignored.
        @(negedge clk);
        start = 1'b1; op = OpMult; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        op = OpMtlo; src_a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mtlo lo", 64'(lo), 64'd42);
        chk("busy_mtlo busy", 64'(busy), 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_mtlo wait", 64'(n < 100), 64'd1);
        chk("busy_mtlo result", 64'(lo), 64'd15);

        // Start with cancel while idle, and unknown op, are both ignored.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OpMult; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b1; op = 4'd12; src_a = 32'h77;
        @(negedge clk);
        start = 1'b0;
        chk("unknown busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("unknown lo", 64'(lo), 64'd15);
        chk("unknown done", 64'(done), 64'd0);

        // Asynchronous reset mid-multiply.
        mt(OpMthi, 32'h1111);
        @(negedge clk);
        start = 1'b1; op = OpMult; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid hi", 64'(hi), 64'd0);
        chk("rst_mid lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rel busy", 64'(busy), 64'd0);
        chk("rst_rel done", 64'(done), 64'd0);
        run_iter("post_reset_multu", OpMultu, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
